serial_incr_sched: RTL and testbench
====================================

# serial_incr_sched

Two-requester scheduler that time-shares one bit-serial 1-bit-per-cycle incrementer datapath. It accepts NBITS-wide words over val/rdy request ports, arbitrates round-robin, and steps the word through the incrementer LSB first, one bit per cycle. It returns the incremented word, the requester id and an overflow flag on a val/rdy response port. It sits between parallel producers and the serial arithmetic slice in the seq_arith family.

## Interface
- NBITS, default 4: operand width in bits; legal range 2..16.
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low; 0 clears all state immediately.
- req0_val  input  1  requester 0 has a word.
- req0_rdy  output  1  scheduler accepts requester 0 this cycle.
- req0_msg  input  NBITS  requester 0 operand.
- req1_val, req1_rdy, req1_msg: same as requester 0, for requester 1.
- resp_val  output  1  result valid.
- resp_rdy  input  1  consumer accepts the result.
- resp_msg  output  NBITS  operand + 1, modulo 2^NBITS.
- resp_id  output  1  id of the requester that supplied the operand.
- resp_ovf  output  1  set when the operand was all ones (wrapped to 0).
- busy  output  1  high in any state other than IDLE.

## Operation
- The FSM has three states: IDLE, CALC, DONE.
- A round-robin pointer, ptr, holds the current priority: 0 gives requester 0 priority, 1 gives requester 1 priority.
- IDLE:
  - req0_rdy = (ptr==0 || !req1_val).
  - req1_rdy = (ptr==1 || !req0_val).
  - Both rdy outputs are forced to 0 outside IDLE.
  - A transfer occurs when val && rdy on one port. The scheduler then:
    - loads the operand into the work register;
    - records the requester id;
    - sets carry to 1 and the bit index idx to 0;
    - sets ptr to the complement of the granted id;
    - moves to CALC.
  - ptr does not change in a cycle with no grant.
- CALC: each cycle:
  - work[idx] <= work[idx] ^ carry;
  - carry <= work[idx] & carry;
  - idx increments by 1.
  - The step with idx == NBITS-1 is the last bit. After it the FSM moves to DONE.
- DONE:
  - resp_val = 1.
  - resp_msg = work, resp_id = recorded id, resp_ovf = final carry.
  - When resp_val && resp_rdy, the FSM moves to IDLE. No new request is accepted in the same cycle.
- Outputs are held stable while resp_val=1 and resp_rdy=0.
- Values after reset:
  - state IDLE, ptr 0;
  - resp_val 0, resp_msg 0, resp_id 0, resp_ovf 0;
  - busy 0, carry 0, idx 0.
- If reset asserts mid-CALC or mid-DONE, the word in flight is discarded. No response is issued for it.

## Timing
- Accept edge T:
  - the last CALC edge is T+NBITS;
  - resp_val rises after edge T+NBITS;
  - the earliest response handshake is edge T+NBITS+1.
- Peak throughput is one word per NBITS+2 cycles (accept, NBITS compute, 1 response).
- req*_rdy depends combinationally on req*_val and state. No other comb paths exist from inputs to outputs.
- resp_* outputs are registered.

## Configuration
- SERIAL_INCR_SCHED_EARLY_DONE_EN
  - Defined: in CALC, when the bit just processed yields a next carry of 0, the FSM moves to DONE on that edge. The remaining upper bits are already correct in place.
    - An operand with its first 0 at bit k (LSB=bit 0) finishes after k+1 CALC cycles.
    - An all-ones operand takes NBITS cycles.
  - Undefined: CALC always takes NBITS cycles, regardless of carry.
- Values of resp_msg, resp_id and resp_ovf are identical either way. Only latency differs.

## Test plan
- Default NBITS=4 is used below.
- Single requester, undefined macro:
  - stimulus: req0 msg 0011 at edge T;
  - required: resp_val first high after T+4, msg 0100, id 0, ovf 0.
- Overflow:
  - stimulus: req1 msg 1111;
  - required: msg 0000, id 1, ovf 1, in NBITS cycles in both configs.
- Round-robin:
  - stimulus: both val held high with msgs 0001 (req0) and 1010 (req1), resp_rdy=1;
  - required: grants alternate 0,1,0,1; responses 0010/id0, 1011/id1, repeating.
- Backpressure:
  - stimulus: resp_rdy=0 for 5 cycles in DONE;
  - required: resp_msg/id/ovf hold steady, req*_rdy=0, busy=1; handshake on the first cycle with resp_rdy=1, then IDLE.
- Reset mid-CALC:
  - stimulus: reset=0 asserted after 2 CALC cycles on msg 0111;
  - required: all outputs return to reset values immediately, no response is issued, ptr=0.
- With SERIAL_INCR_SCHED_EARLY_DONE_EN defined:
  - msg 0110: resp_val rises after T+1, result 0111;
  - msg 1011: resp_val rises after T+3, result 1100.

Source files
------------

// File: rtl/serial_incr_sched.sv
// Round-robin two-requester front end sharing one bit-serial +1 datapath.
// Optional SERIAL_INCR_SCHED_EARLY_DONE_EN ends CALC as soon as the carry dies out.
module serial_incr_sched #(
    parameter int unsigned NBITS = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_val,
    output logic             req0_rdy,
    input  logic [NBITS-1:0] req0_msg,
    input  logic             req1_val,
    output logic             req1_rdy,
    input  logic [NBITS-1:0] req1_msg,
    output logic             resp_val,
    input  logic             resp_rdy,
    output logic [NBITS-1:0] resp_msg,
    output logic             resp_id,
    output logic             resp_ovf,
    output logic             busy
);

    localparam int unsigned IdxW = (NBITS > 2) ? $clog2(NBITS) : 1;

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e            state_q, state_d;
    logic              ptr_q, ptr_d;
    logic [NBITS-1:0]  work_q, work_d;
    logic              id_q, id_d;
    logic              carry_q, carry_d;
    logic [IdxW-1:0]   idx_q, idx_d;

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        work_d   = work_q;
        id_d     = id_q;
        carry_d  = carry_q;
        idx_d    = idx_q;
        req0_rdy = 1'b0;
        req1_rdy = 1'b0;

        unique case (state_q)
            StIdle: begin
                req0_rdy = !ptr_q || !req1_val;
                req1_rdy = ptr_q || !req0_val;
                if (req0_val && req0_rdy) begin
                    work_d  = req0_msg;
                    id_d    = 1'b0;
                    carry_d = 1'b1;
                    idx_d   = '0;
                    ptr_d   = 1'b1;
                    state_d = StCalc;
                end else if (req1_val && req1_rdy) begin
                    work_d  = req1_msg;
                    id_d    = 1'b1;
                    carry_d = 1'b1;
                    idx_d   = '0;
                    ptr_d   = 1'b0;
                    state_d = StCalc;
                end
            end
            StCalc: begin
                // One half-adder step on the current bit, in place.
                work_d[idx_q] = work_q[idx_q] ^ carry_q;
                carry_d       = work_q[idx_q] & carry_q;
                idx_d         = idx_q + IdxW'(1);
                if (idx_q == IdxW'(NBITS - 1)) begin
                    state_d = StDone;
                    idx_d   = '0;
                end
`ifdef SERIAL_INCR_SCHED_EARLY_DONE_EN
                // Once the carry is gone the upper bits are already final.
                else if (!carry_d) begin
                    state_d = StDone;
                    idx_d   = '0;
                end
`endif
            end
            StDone: begin
                if (resp_rdy) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            ptr_q   <= 1'b0;
            work_q  <= '0;
            id_q    <= 1'b0;
            carry_q <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            work_q  <= work_d;
            id_q    <= id_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
        end
    end

    assign resp_val = (state_q == StDone);
    assign resp_msg = work_q;
    assign resp_id  = id_q;
    assign resp_ovf = carry_q;
    assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_serial_incr_sched.sv
// Bench for serial_incr_sched: directed vector table, corner sequences and a
// randomized run checked against a transaction-level reference model.
module tb_serial_incr_sched;

    localparam int unsigned N = 4;

    logic         clk;
    logic         reset;
    logic         req0_val, req0_rdy;
    logic [N-1:0] req0_msg;
    logic         req1_val, req1_rdy;
    logic [N-1:0] req1_msg;
    logic         resp_val, resp_rdy;
    logic [N-1:0] resp_msg;
    logic         resp_id, resp_ovf, busy;

    int checks = 0;
    int errors = 0;

    serial_incr_sched #(.NBITS(N)) dut (
        .clk      (clk),
        .reset    (reset),
        .req0_val (req0_val),
        .req0_rdy (req0_rdy),
        .req0_msg (req0_msg),
        .req1_val (req1_val),
        .req1_rdy (req1_rdy),
        .req1_msg (req1_msg),
        .resp_val (resp_val),
        .resp_rdy (resp_rdy),
        .resp_msg (resp_msg),
        .resp_id  (resp_id),
        .resp_ovf (resp_ovf),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit           id;
        logic [N-1:0] msg;
        logic [N-1:0] exp_msg;
        bit           exp_ovf;
        int           lat_def;
        int           lat_early;
    } vec_t;

    typedef struct {
        bit           id;
        logic [N-1:0] msg;
        bit           ovf;
        int           lat;
        int           acc;
        bit           seen;
    } exp_t;

    vec_t vecs[7];
    exp_t q[$];
    bit   ptr_m;
    int   cyc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b1;
        step();
    endtask

    // Latency from the spec's rules: first zero bit position + 1 when early-done.
    function automatic int lat_of(input logic [N-1:0] m);
`ifdef SERIAL_INCR_SCHED_EARLY_DONE_EN
        for (int k = 0; k < int'(N); k++) begin
            if (m[k] == 1'b0) return k + 1;
        end
`endif
        return int'(N);
    endfunction

    task automatic send(input bit id, input logic [N-1:0] msg, input logic [N-1:0] emsg,
                        input bit eovf, input int elat, input int hold, input string tag);
        int cnt;
        logic [N-1:0] held;
        if (id) begin
            req1_val = 1'b1;
            req1_msg = msg;
        end else begin
            req0_val = 1'b1;
            req0_msg = msg;
        end
        #1;
        check({tag, "_grant"}, 32'(id ? req1_rdy : req0_rdy), 32'd1);
        step();
        req0_val = 1'b0;
        req1_val = 1'b0;
        cnt = 0;
        while (!resp_val && cnt < 40) begin
            step();
            cnt++;
        end
        check({tag, "_lat"}, 32'(cnt), 32'(elat));
        check({tag, "_msg"}, 32'(resp_msg), 32'(emsg));
        check({tag, "_id"}, 32'(resp_id), 32'(id));
        check({tag, "_ovf"}, 32'(resp_ovf), 32'(eovf));
        held = resp_msg;
        for (int h = 0; h < hold; h++) begin
            req0_val = 1'b1;
            req1_val = 1'b1;
            #1;
            check({tag, "_bp_rdy0"}, 32'(req0_rdy), 32'd0);
            check({tag, "_bp_rdy1"}, 32'(req1_rdy), 32'd0);
            req0_val = 1'b0;
            req1_val = 1'b0;
            step();
            check({tag, "_bp_val"}, 32'(resp_val), 32'd1);
            check({tag, "_bp_busy"}, 32'(busy), 32'd1);
            check({tag, "_bp_msg"}, 32'({resp_msg, resp_id, resp_ovf}),
                  32'({held, id, eovf}));
        end
        resp_rdy = 1'b1;
        step();
        resp_rdy = 1'b0;
        check({tag, "_post_val"}, 32'(resp_val), 32'd0);
        check({tag, "_post_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic model_cycle(input bit drive);
        bit   g0, g1, exp_g1;
        exp_t e;
        if (drive) begin
            req0_val = 1'($urandom_range(0, 1));
            req1_val = 1'($urandom_range(0, 1));
            req0_msg = N'($urandom);
            req1_msg = N'($urandom);
            resp_rdy = ($urandom_range(0, 3) != 0);
        end else begin
            req0_val = 1'b0;
            req1_val = 1'b0;
            resp_rdy = 1'b1;
        end
        #1;
        if (q.size() == 0) begin
            check("rnd_rdy0", 32'(req0_rdy), 32'(!ptr_m || !req1_val));
            check("rnd_rdy1", 32'(req1_rdy), 32'(ptr_m || !req0_val));
            check("rnd_idle_val", 32'(resp_val), 32'd0);
        end else begin
            check("rnd_busy_rdy", 32'({req0_rdy, req1_rdy}), 32'd0);
            e = q[0];
            if (resp_val) begin
                if (!e.seen) begin
                    check("rnd_lat", 32'(cyc - e.acc), 32'(e.lat));
                    e.seen = 1'b1;
                    q[0] = e;
                end
                check("rnd_msg", 32'(resp_msg), 32'(e.msg));
                check("rnd_id", 32'(resp_id), 32'(e.id));
                check("rnd_ovf", 32'(resp_ovf), 32'(e.ovf));
                if (resp_rdy) void'(q.pop_front());
            end else if (e.seen) begin
                check("rnd_val_drop", 32'(resp_val), 32'd1);
            end
        end
        g0 = req0_val && req0_rdy;
        g1 = req1_val && req1_rdy;
        if ((g0 || g1) && q.size() == 0) begin
            exp_g1 = (req0_val && req1_val) ? ptr_m : !req0_val;
            check("rnd_grant", 32'({g0, g1}), 32'({!exp_g1, exp_g1}));
            e.id   = g1;
            e.msg  = g1 ? N'(req1_msg + 1'b1) : N'(req0_msg + 1'b1);
            e.ovf  = g1 ? (req1_msg == '1) : (req0_msg == '1);
            e.lat  = lat_of(g1 ? req1_msg : req0_msg);
            e.acc  = cyc + 1;
            e.seen = 1'b0;
            q.push_back(e);
            ptr_m = !g1;
        end
        step();
        cyc++;
    endtask

    initial begin
        int cnt;
        vecs[0] = '{1'b0, 4'b0011, 4'b0100, 1'b0, 4, 3};
        vecs[1] = '{1'b1, 4'b1111, 4'b0000, 1'b1, 4, 4};
        vecs[2] = '{1'b0, 4'b0110, 4'b0111, 1'b0, 4, 1};
        vecs[3] = '{1'b1, 4'b1011, 4'b1100, 1'b0, 4, 3};
        vecs[4] = '{1'b0, 4'b0000, 4'b0001, 1'b0, 4, 1};
        vecs[5] = '{1'b1, 4'b0111, 4'b1000, 1'b0, 4, 4};
        vecs[6] = '{1'b0, 4'b1110, 4'b1111, 1'b0, 4, 1};

        reset    = 1'b0;
        req0_val = 1'b0;
        req1_val = 1'b0;
        req0_msg = '0;
        req1_msg = '0;
        resp_rdy = 1'b0;
        #12;
        check("rst_val", 32'(resp_val), 32'd0);
        check("rst_msg", 32'(resp_msg), 32'd0);
        check("rst_id", 32'(resp_id), 32'd0);
        check("rst_ovf", 32'(resp_ovf), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        do_reset();

        foreach (vecs[i]) begin
`ifdef SERIAL_INCR_SCHED_EARLY_DONE_EN
            send(vecs[i].id, vecs[i].msg, vecs[i].exp_msg, vecs[i].exp_ovf,
                 vecs[i].lat_early, 0, $sformatf("vec%0d", i));
`else
            send(vecs[i].id, vecs[i].msg, vecs[i].exp_msg, vecs[i].exp_ovf,
                 vecs[i].lat_def, 0, $sformatf("vec%0d", i));
`endif
        end

        // Backpressure: five cycles stalled in DONE.
        send(1'b0, 4'b1001, 4'b1010, 1'b0, lat_of(4'b1001), 5, "bp");

        // Round-robin with both requesters always valid.
        do_reset();
        req0_val = 1'b1;
        req0_msg = 4'b0001;
        req1_val = 1'b1;
        req1_msg = 4'b1010;
        resp_rdy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cnt = 0;
            while (busy && cnt < 40) begin
                step();
                cnt++;
            end
            #1;
            check("rr_rdy", 32'({req0_rdy, req1_rdy}), (k % 2 == 0) ? 32'd2 : 32'd1);
            step();
            cnt = 0;
            while (!resp_val && cnt < 40) begin
                step();
                cnt++;
            end
            check("rr_id", 32'(resp_id), 32'(k % 2));
            check("rr_msg", 32'(resp_msg), (k % 2 == 0) ? 32'h2 : 32'hb);
            step();
        end
        req0_val = 1'b0;
        req1_val = 1'b0;
        resp_rdy = 1'b0;
        step();

        // Reset two cycles into CALC; leaves ptr at 1 unless reset clears it.
        do_reset();
        req0_val = 1'b1;
        req0_msg = 4'b0111;
        step();
        req0_val = 1'b0;
        step();
        step();
        check("mid_busy_pre", 32'(busy), 32'd1);
        reset = 1'b0;
        #1;
        check("mid_val", 32'(resp_val), 32'd0);
        check("mid_msg", 32'(resp_msg), 32'd0);
        check("mid_id", 32'(resp_id), 32'd0);
        check("mid_ovf", 32'(resp_ovf), 32'd0);
        check("mid_busy", 32'(busy), 32'd0);
        req0_val = 1'b1;
        req1_val = 1'b1;
        #1;
        check("mid_ptr", 32'({req0_rdy, req1_rdy}), 32'd2);
        req0_val = 1'b0;
        req1_val = 1'b0;
        step();
        reset = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            check("mid_no_resp", 32'(resp_val), 32'd0);
        end

        // Randomized traffic against the reference model.
        do_reset();
        ptr_m = 1'b0;
        cyc   = 0;
        q.delete();
        for (int k = 0; k < 1500; k++) model_cycle(1'b1);
        for (int k = 0; k < 30; k++) model_cycle(1'b0);
        check("rnd_drained", 32'(q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
